// File: rtl/mem_a_read_requester_if.sv
// Bus bundle for the A-memory read requester: address FIFO, memory request/response and row output.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1; valid never depends on ready.
interface mem_a_read_requester_if #(
  parameter int BUS_WIDTH_BYTES = 32,
  parameter int ARRAY_HEIGHT    = 4
);
  localparam int DW = 8 * BUS_WIDTH_BYTES;
  localparam int IW = $clog2(ARRAY_HEIGHT);

  logic [15:0]   a_fifo_addr;
  logic          a_fifo_empty;
  logic          a_fifo_pop;
  logic          mem_req_valid;
  logic [15:0]   mem_req_addr;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          row_valid;
  logic [DW-1:0] row_data;
  logic [IW-1:0] row_idx;
  logic          row_last;
  logic          row_ready;

  modport master (
    input  a_fifo_addr, a_fifo_empty,
    output a_fifo_pop,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output row_valid, row_data, row_idx, row_last,
    input  row_ready
  );

  modport slave (
    output a_fifo_addr, a_fifo_empty,
    input  a_fifo_pop,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  row_valid, row_data, row_idx, row_last,
    output row_ready
  );
endinterface

// File: rtl/mem_a_read_requester.sv
// Pops A row addresses, issues one bus-wide read per address and returns the words in order,
// tagged with their array row index. Credits bound words popped-but-not-consumed to MAX_OUTSTANDING.
module mem_a_read_requester #(
  parameter int BUS_WIDTH_BYTES  = 32,
  parameter int DATA_WIDTH_BYTES = 1,
  parameter int ARRAY_HEIGHT     = 4,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_a_read_requester_if.master   bus,
  output logic                     busy,
  output logic                     err_o,
  output logic [0:0]               dbg_state
);
  localparam int DW    = 8 * BUS_WIDTH_BYTES;
  localparam int IW    = $clog2(ARRAY_HEIGHT);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [IW-1:0]    LAST_IDX = IW'(ARRAY_HEIGHT - 1);

  localparam logic [0:0] IDL = 1'b0;
  localparam logic [0:0] REQ = 1'b1;

  if ((BUS_WIDTH_BYTES % DATA_WIDTH_BYTES) != 0 || ARRAY_HEIGHT < 2 ||
      (ARRAY_HEIGHT & (ARRAY_HEIGHT - 1)) != 0 || MAX_OUTSTANDING < 1) begin : g_bad_params
    $error("mem_a_read_requester: illegal parameter combination");
  end

  logic [0:0]       state;
  logic             req_valid_q;
  logic [15:0]      req_addr_q;
  logic [CNT_W-1:0] credit_cnt;
  logic [CNT_W-1:0] pend_cnt;
  logic [CNT_W-1:0] buf_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DW-1:0]    rsp_buf [MAX_OUTSTANDING];
  logic [IW-1:0]    row_idx_q;
  logic             err_q;

  logic can_pop;
  logic pop;
  logic req_hs;
  logic row_hs;
  logic row_valid;
  logic pend_dec;
  logic rsp_drop;
  logic buf_wr;

  assign can_pop   = ~bus.a_fifo_empty & (credit_cnt < MAX_CNT);
  assign req_hs    = req_valid_q & bus.mem_req_ready;
  assign row_valid = (buf_cnt != '0);
  assign row_hs    = row_valid & bus.row_ready;

  // A response with nothing pending, or one that would overflow the buffer, is discarded and flagged.
  assign pend_dec = bus.mem_rsp_valid & (pend_cnt != '0);
  assign rsp_drop = bus.mem_rsp_valid & ((pend_cnt == '0) | ((buf_cnt == MAX_CNT) & ~row_hs));
  assign buf_wr   = bus.mem_rsp_valid & ~rsp_drop;

  always_comb begin
    pop = 1'b0;
    case (state)
      IDL:     pop = can_pop;
      REQ:     pop = bus.mem_req_ready & can_pop;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDL;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      case (state)
        IDL: begin
          if (pop) begin
            req_addr_q  <= bus.a_fifo_addr;
            req_valid_q <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          // Back-to-back: the next address replaces the accepted one on the same edge.
          if (bus.mem_req_ready) begin
            if (pop) begin
              req_addr_q <= bus.a_fifo_addr;
            end else begin
              req_valid_q <= 1'b0;
              state       <= IDL;
            end
          end
        end
        default: begin
          req_valid_q <= 1'b0;
          state       <= IDL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_cnt <= '0;
      pend_cnt   <= '0;
      buf_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      row_idx_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pop && !row_hs)      credit_cnt <= credit_cnt + 1'b1;
      else if (!pop && row_hs) credit_cnt <= credit_cnt - 1'b1;

      if (req_hs && !pend_dec)      pend_cnt <= pend_cnt + 1'b1;
      else if (!req_hs && pend_dec) pend_cnt <= pend_cnt - 1'b1;

      if (buf_wr && !row_hs)      buf_cnt <= buf_cnt + 1'b1;
      else if (!buf_wr && row_hs) buf_cnt <= buf_cnt - 1'b1;

      if (buf_wr) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (row_hs) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

      // Row index keeps counting across idle periods; only reset realigns it.
      if (row_hs) row_idx_q <= (row_idx_q == LAST_IDX) ? '0 : row_idx_q + 1'b1;

      if (rsp_drop) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr) rsp_buf[wr_ptr] <= bus.mem_rsp_data;
  end

  assign bus.a_fifo_pop    = pop;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.row_valid     = row_valid;
  assign bus.row_data      = row_valid ? rsp_buf[rd_ptr] : '0;
  assign bus.row_idx       = row_idx_q;
  assign bus.row_last      = row_valid & (row_idx_q == LAST_IDX);
  assign busy              = (state != IDL) | (credit_cnt != '0);
  assign err_o             = err_q;
  assign dbg_state         = state;
endmodule
